// File: rtl/wb_arbiter_rr_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter.
// Cycle type ids, FSM state encoding and a width helper.
package wb_arbiter_rr_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after last, wrapping.
// Purely combinational.
module wb_arbiter_rr_pick
  import wb_arbiter_rr_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IW = clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          last,
  output logic [IW-1:0]          idx,
  output logic                   any
);

  logic [IW-1:0] j;

  // Scan farthest-to-nearest so the nearest requester overwrites
  always_comb begin
    idx = '0;
    j   = '0;
    any = |req;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      j = IW'((int'(last) + k) % NUM_MASTERS);
      if (req[j]) idx = j;
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B3 arbiter, grant held until owner drops cyc.
// Optional owner watchdog: define WB_ARB_WATCHDOG_EN.
module wb_arbiter_rr
  import wb_arbiter_rr_pkg::*;
#(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic [NUM_MASTERS*aw-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*dw-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
  output logic [NUM_MASTERS*dw-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [aw-1:0]             wbs_adr_o,
  output logic [dw-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [dw-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i
);

  localparam int IW = clog2(NUM_MASTERS);

  arb_state_e    state, state_n;
  logic [IW-1:0] grant_idx, grant_idx_n;
  logic [IW-1:0] last_idx, last_idx_n;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          grant_vld;
  logic          wd_hit;

  logic [aw-1:0] adr_a [NUM_MASTERS];
  logic [dw-1:0] dat_a [NUM_MASTERS];
  logic [3:0]    sel_a [NUM_MASTERS];
  logic [2:0]    cti_a [NUM_MASTERS];
  logic [1:0]    bte_a [NUM_MASTERS];

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_m
    assign adr_a[m] = wbm_adr_i[m*aw +: aw];
    assign dat_a[m] = wbm_dat_i[m*dw +: dw];
    assign sel_a[m] = wbm_sel_i[m*4 +: 4];
    assign cti_a[m] = wbm_cti_i[m*3 +: 3];
    assign bte_a[m] = wbm_bte_i[m*2 +: 2];
    assign wbm_ack_o[m] = grant_vld & (grant_idx == IW'(m)) & wbs_ack_i;
    assign wbm_err_o[m] = grant_vld & (grant_idx == IW'(m)) &
                          (wbs_err_i | wd_hit);
    assign wbm_rty_o[m] = grant_vld & (grant_idx == IW'(m)) & wbs_rty_i;
  end

  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign grant_vld = (state == S_OWNED);

  wb_arbiter_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IW         (IW)
  ) u_pick (
    .req (wbm_cyc_i),
    .last(last_idx),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant state; master 0 wins first after reset
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state     <= S_IDLE;
      grant_idx <= '0;
      last_idx  <= IW'(NUM_MASTERS - 1);
    end else begin
      state     <= state_n;
      grant_idx <= grant_idx_n;
      last_idx  <= last_idx_n;
    end
  end

  // Grant on any request; release only when the owner drops cyc
  always_comb begin
    state_n     = state;
    grant_idx_n = grant_idx;
    last_idx_n  = last_idx;
    unique case (state)
      S_IDLE: begin
        if (pick_any) begin
          state_n     = S_OWNED;
          grant_idx_n = pick_idx;
        end
      end
      S_OWNED: begin
        if (!wbm_cyc_i[grant_idx]) begin
          state_n    = S_IDLE;
          last_idx_n = grant_idx;
        end
      end
    endcase
  end

  // Request mux from the owner, all zero while nobody owns the bus
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (grant_vld) begin
      wbs_adr_o = adr_a[grant_idx];
      wbs_dat_o = dat_a[grant_idx];
      wbs_sel_o = sel_a[grant_idx];
      wbs_we_o  = wbm_we_i[grant_idx];
      wbs_cyc_o = wbm_cyc_i[grant_idx];
      wbs_stb_o = wbm_stb_i[grant_idx] & ~wd_hit;
      wbs_cti_o = cti_a[grant_idx];
      wbs_bte_o = bte_a[grant_idx];
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;

  assign wd_hit = grant_vld & wbm_stb_i[grant_idx] &
                  (wd_cnt == 16'(TIMEOUT - 1));

  // Count stalled strobe clocks; any slave response or release clears
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wd_cnt <= '0;
    end else if (!grant_vld || wbs_ack_i || wbs_err_i ||
                 wbs_rty_i || wd_hit) begin
      wd_cnt <= '0;
    end else if (wbm_stb_i[grant_idx]) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: directed scenarios then random traffic.
// Expected outputs come from an integer-level ownership model.
module tb_wb_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef WB_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [AW-1:0] m_adr [N];
  logic [DW-1:0] m_dat [N];
  logic [3:0]    m_sel [N];
  logic [2:0]    m_cti [N];
  logic [1:0]    m_bte [N];
  logic [N-1:0]  m_we, m_cyc, m_stb;

  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*4-1:0]  wbm_sel_i;
  logic [N*3-1:0]  wbm_cti_i;
  logic [N*2-1:0]  wbm_bte_i;
  logic [N*DW-1:0] wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [3:0]      wbs_sel_o;
  logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic [DW-1:0]   s_dat;
  logic            s_ack, s_err, s_rty;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign wbm_adr_i[g*AW +: AW] = m_adr[g];
    assign wbm_dat_i[g*DW +: DW] = m_dat[g];
    assign wbm_sel_i[g*4 +: 4]   = m_sel[g];
    assign wbm_cti_i[g*3 +: 3]   = m_cti[g];
    assign wbm_bte_i[g*2 +: 2]   = m_bte[g];
  end

  wb_arbiter_rr #(
    .dw(DW), .aw(AW), .NUM_MASTERS(N), .TIMEOUT(TO)
  ) dut (
    .wb_clk(clk), .wb_rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i),
    .wbm_sel_i(wbm_sel_i), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack),
    .wbs_err_i(s_err), .wbs_rty_i(s_rty)
  );

  int checks = 0;
  int errors = 0;
  int owner;
  int last;
  int wd;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic bit exp_hit();
    if (!WD || owner < 0) return 1'b0;
    return m_stb[owner] && (wd == TO - 1);
  endfunction

  task automatic check_model();
    bit            h;
    logic [N-1:0]  oh;
    h  = exp_hit();
    oh = (owner >= 0) ? (N'(1) << owner) : '0;
    if (owner >= 0) begin
      chk("cyc", wbs_cyc_o, m_cyc[owner]);
      chk("stb", wbs_stb_o, m_stb[owner] && !h);
      chk("adr", wbs_adr_o, m_adr[owner]);
      chk("wdat", wbs_dat_o, m_dat[owner]);
      chk("sel", wbs_sel_o, m_sel[owner]);
      chk("we", wbs_we_o, m_we[owner]);
      chk("cti", wbs_cti_o, m_cti[owner]);
      chk("bte", wbs_bte_o, m_bte[owner]);
    end else begin
      chk("idle_req", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o,
                       wbs_cti_o, wbs_bte_o, wbs_adr_o, wbs_dat_o}, 0);
    end
    chk("ack", wbm_ack_o, s_ack ? oh : '0);
    chk("err", wbm_err_o, (s_err || h) ? oh : '0);
    chk("rty", wbm_rty_o, s_rty ? oh : '0);
    chk("rdat", wbm_dat_o, {N{s_dat}});
  endtask

  task automatic update_model();
    bit h;
    if (rst) begin
      owner = -1;
      last  = N - 1;
      wd    = 0;
      return;
    end
    h = exp_hit();
    if (WD) begin
      if (owner < 0 || s_ack || s_err || s_rty || h) wd = 0;
      else if (m_stb[owner]) wd++;
    end
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (m_cyc[j]) begin
          owner = j;
          break;
        end
      end
    end else if (!m_cyc[owner]) begin
      last  = owner;
      owner = -1;
    end
  endtask

  task automatic tick();
    #1 check_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int m = 0; m < N; m++) begin
      m_adr[m] = AW'(m) << 12;
      m_dat[m] = '0;
      m_sel[m] = 4'hf;
      m_cti[m] = 3'b000;
      m_bte[m] = 2'b00;
    end
    m_we  = '0;
    m_cyc = '0;
    m_stb = '0;
    s_dat = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
  endtask

  logic [3:0]   trace [10];
  logic [3:0]   exp2  [10];
  logic [N-1:0] acked;
  logic         e6;

  initial begin
    exp2 = '{4'hf, 4'h0, 4'hf, 4'hf, 4'h1,
             4'hf, 4'hf, 4'h2, 4'hf, 4'hf};
    owner = -1;
    last  = N - 1;
    wd    = 0;
    rst   = 1'b1;
    idle_all();
    @(negedge clk);
    @(posedge clk);
    update_model();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cyc", wbs_cyc_o, 0);
    chk("rst_ack", wbm_ack_o, 0);
    tick();

    // single read by m0
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h0000_0100;
    #1 chk("t1_lat", wbs_cyc_o, 0);
    tick();
    s_ack = 1'b1;
    s_dat = 32'hDEAD_BEEF;
    #1;
    chk("t1_cyc", wbs_cyc_o, 1);
    chk("t1_dat", wbm_dat_o[31:0], 32'hDEAD_BEEF);
    chk("t1_ack", wbm_ack_o, 4'b0001);
    tick();
    idle_all();
    tick();
    tick();

    // three simultaneous requesters after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int m = 0; m < 3; m++) begin
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
    end
    for (int c = 0; c < 10; c++) begin
      #1 s_ack = wbs_stb_o;
      #1;
      trace[c] = wbs_cyc_o ? wbs_adr_o[15:12] : 4'hf;
      acked = wbm_ack_o;
      tick();
      for (int m = 0; m < N; m++) begin
        if (acked[m]) begin
          m_cyc[m] = 1'b0;
          m_stb[m] = 1'b0;
        end
      end
      s_ack = 1'b0;
    end
    for (int c = 0; c < 10; c++) chk("t2_trace", trace[c], exp2[c]);
    idle_all();
    tick();

    // m1 incrementing burst must not be preempted by m3
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    m_cti[1] = 3'b010;
    tick();
    m_cyc[3] = 1'b1;
    m_stb[3] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
      m_adr[1] = 32'h1000 + 32'(b * 4);
      s_ack = 1'b1;
      #1;
      chk("t3_adr", wbs_adr_o, 32'h1000 + 32'(b * 4));
      chk("t3_cti", wbs_cti_o, (b == 3) ? 3'b111 : 3'b010);
      chk("t3_ack", wbm_ack_o, 4'b0010);
      tick();
    end
    s_ack = 1'b0;
    m_stb[1] = 1'b0;
    #1;
    chk("t3_hold_cyc", wbs_cyc_o, 1);
    chk("t3_hold_own", wbs_adr_o[15:12], 4'h1);
    tick();
    m_cyc[1] = 1'b0;
    m_cti[1] = 3'b000;
    tick();
    #1 chk("t3_gap", wbs_cyc_o, 0);
    tick();
    #1;
    chk("t3_m3_cyc", wbs_cyc_o, 1);
    chk("t3_m3_adr", wbs_adr_o, 32'h3000);
    s_ack = 1'b1;
    tick();
    idle_all();
    tick();
    tick();

    // reset while m2 owns the bus
    m_cyc[2] = 1'b1;
    m_stb[2] = 1'b1;
    tick();
    #1 chk("t4_own", wbs_adr_o, 32'h2000);
    rst = 1'b1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h0000_0A00;
    s_ack = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t4_cyc", wbs_cyc_o, 0);
    chk("t4_ack", wbm_ack_o, 0);
    tick();
    #1;
    chk("t4_next_cyc", wbs_cyc_o, 1);
    chk("t4_next_adr", wbs_adr_o, 32'h0000_0A00);
    idle_all();
    tick();
    tick();

    // error response routed to m1 only
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    tick();
    s_err = 1'b1;
    #1;
    chk("t5_err", wbm_err_o, 4'b0010);
    chk("t5_ack", wbm_ack_o, 4'b0000);
    tick();
    idle_all();
    tick();
    tick();

    // stalled slave: watchdog error only when enabled
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      #1;
      e6 = wbm_err_o[0];
      chk("t6_wd", e6, WD && (k % TO == 0));
      tick();
    end
    idle_all();
    tick();
    tick();

    // random traffic against the model
    for (int c = 0; c < 800; c++) begin
      int r;
      for (int m = 0; m < N; m++) begin
        if (m_cyc[m]) m_cyc[m] = ($urandom_range(0, 5) != 0);
        else          m_cyc[m] = ($urandom_range(0, 3) == 0);
        m_stb[m] = m_cyc[m] ? ($urandom_range(0, 3) != 0)
                            : ($urandom_range(0, 7) == 0);
        m_we[m]  = 1'($urandom);
        m_adr[m] = $urandom;
        m_dat[m] = $urandom;
        m_sel[m] = 4'($urandom);
        m_cti[m] = 3'($urandom);
        m_bte[m] = 2'($urandom);
      end
      r = $urandom_range(0, 7);
      s_ack = (r < 3);
      s_err = (r == 3);
      s_rty = (r == 4);
      s_dat = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
